// File: rtl/voq_rr_scheduler.sv
// Read-side round-robin scheduler for the shared-buffer VOQ with per-egress credits.
// Define VOQ_SCHED_WRR_EN for weighted round robin driven by cfg_weight.
module voq_rr_scheduler #(
  parameter int QUEUE_NUB  = 4,
  parameter int CREDIT_MAX = 4,
  parameter int WEIGHT_W   = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sched_en,
  input  logic [QUEUE_NUB-1:0]          queue_empty,
  input  logic [QUEUE_NUB-1:0]          credit_ret,
`ifdef VOQ_SCHED_WRR_EN
  input  logic [QUEUE_NUB*WEIGHT_W-1:0] cfg_weight,
`endif
  output logic                          rd_en,
  output logic [$clog2(QUEUE_NUB)-1:0]  rd_client,
  output logic                          out_valid,
  output logic [$clog2(QUEUE_NUB)-1:0]  out_client,
  output logic                          credit_err,
  output logic [1:0]                    dbg_state
);
  localparam int QW = $clog2(QUEUE_NUB);
  localparam int CW = $clog2(CREDIT_MAX + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  // Handshake: rd_en is a one-cycle request the VOQ always accepts (no ready);
  // out_valid/out_client qualify rd_data exactly one cycle after each rd_en.
  logic [1:0]           state;
  logic [QW-1:0]        rr_ptr, pick, ptr_inc;
  logic [CW-1:0]        credit [QUEUE_NUB];
  logic [QUEUE_NUB-1:0] eligible, cand, dec;
  logic                 pick_ok, hold_stay, grant;
  int                   scan_idx;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < QUEUE_NUB; i++)
      eligible[i] = !queue_empty[i] && (credit[i] != '0) && sched_en;
  end

  // In HOLD the empty flag of the queue just read is stale, so it is masked out.
  always_comb begin
    cand = eligible;
    if (state == HOLD) cand[rd_client] = 1'b0;
    pick     = '0;
    pick_ok  = 1'b0;
    scan_idx = 0;
    for (int k = 0; k < QUEUE_NUB; k++) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= QUEUE_NUB) scan_idx = scan_idx - QUEUE_NUB;
      if (!pick_ok && cand[scan_idx]) begin
        pick    = QW'(scan_idx);
        pick_ok = 1'b1;
      end
    end
  end

  assign ptr_inc = (int'(rd_client) == QUEUE_NUB - 1) ? '0 : rd_client + 1'b1;

`ifdef VOQ_SCHED_WRR_EN
  logic [WEIGHT_W-1:0] burst_cnt, turn_w, cfg_w, w_eff, cnt_next;
  logic                burst_cont;

  // burst_cnt counts grants already given in the turn owned by rr_ptr.
  always_comb begin
    cfg_w = cfg_weight[int'(rd_client)*WEIGHT_W +: WEIGHT_W];
    if (cfg_w == '0) cfg_w = WEIGHT_W'(1);
    burst_cont = (rd_client == rr_ptr) && (burst_cnt != '0);
    w_eff      = burst_cont ? turn_w : cfg_w;
    cnt_next   = burst_cont ? burst_cnt + 1'b1 : WEIGHT_W'(1);
  end

  // A queue still owning its turn goes back through IDLE to respect the same-queue gap.
  assign hold_stay = (rr_ptr == rd_client);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt <= '0;
      turn_w    <= '0;
    end else if (state == READ) begin
      if (!burst_cont) turn_w <= cfg_w;
      burst_cnt <= (cnt_next >= w_eff) ? '0 : cnt_next;
    end
  end
`else
  localparam int unused_weight_w = WEIGHT_W;
  assign hold_stay = 1'b0;
`endif

  always_comb begin
    grant = 1'b0;
    if (state == IDLE)      grant = pick_ok;
    else if (state == HOLD) grant = pick_ok && !hold_stay;
  end

  always_comb begin
    dec = '0;
    for (int i = 0; i < QUEUE_NUB; i++)
      dec[i] = grant && (pick == QW'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rd_en      <= 1'b0;
      rd_client  <= '0;
      out_valid  <= 1'b0;
      out_client <= '0;
      rr_ptr     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            state     <= READ;
            rd_en     <= 1'b1;
            rd_client <= pick;
          end
        end
        READ: begin
          state      <= HOLD;
          rd_en      <= 1'b0;
          out_valid  <= 1'b1;
          out_client <= rd_client;
`ifdef VOQ_SCHED_WRR_EN
          rr_ptr     <= (cnt_next >= w_eff) ? ptr_inc : rd_client;
`else
          rr_ptr     <= ptr_inc;
`endif
        end
        HOLD: begin
          out_valid <= 1'b0;
          if (grant) begin
            state     <= READ;
            rd_en     <= 1'b1;
            rd_client <= pick;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          rd_en     <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // A grant and a return on the same port in one cycle cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QUEUE_NUB; i++) credit[i] <= CW'(CREDIT_MAX);
      credit_err <= 1'b0;
    end else begin
      for (int i = 0; i < QUEUE_NUB; i++) begin
        if (credit_ret[i] && !dec[i]) begin
          if (credit[i] == CW'(CREDIT_MAX)) credit_err <= 1'b1;
          else                              credit[i] <= credit[i] + 1'b1;
        end else if (!credit_ret[i] && dec[i]) begin
          credit[i] <= credit[i] - 1'b1;
        end
      end
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_voq_rr_scheduler.sv
// Self-checking bench for voq_rr_scheduler: directed steps plus randomized traffic
// checked every cycle against a timing-rule reference model.
module tb_voq_rr_scheduler;
  localparam int N    = 4;
  localparam int CMAX = 4;
  localparam int WW   = 3;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sched_en = 1'b0;
  logic [N-1:0] queue_empty = '1;
  logic [N-1:0] credit_ret = '0;
`ifdef VOQ_SCHED_WRR_EN
  logic [N*WW-1:0] cfg_weight = '0;
`endif
  logic rd_en, out_valid, credit_err;
  logic [1:0] rd_client, out_client, dbg_state;

  int checks = 0;
  int failures = 0;

  // reference model state
  int   t;
  int   last_grant [N];
  int   last_any;
  int   m_ptr;
  int   m_credit [N];
  logic m_err;
  logic m_rd_en;
  int   m_client;
  int   m_burst;
  int   m_turn_w;
  logic [1:0] exp_q[$];
  logic [1:0] order_q[$];
  int   grants [N];
  int   found;

  always #5 clk = ~clk;

  voq_rr_scheduler #(.QUEUE_NUB(N), .CREDIT_MAX(CMAX), .WEIGHT_W(WW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sched_en   (sched_en),
    .queue_empty(queue_empty),
    .credit_ret (credit_ret),
`ifdef VOQ_SCHED_WRR_EN
    .cfg_weight (cfg_weight),
`endif
    .rd_en      (rd_en),
    .rd_client  (rd_client),
    .out_valid  (out_valid),
    .out_client (out_client),
    .credit_err (credit_err),
    .dbg_state  (dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    t = 0;
    for (int i = 0; i < N; i++) begin
      last_grant[i] = -100;
      m_credit[i]   = CMAX;
    end
    last_any = -100;
    m_ptr = 0; m_err = 1'b0; m_rd_en = 1'b0; m_client = 0;
    m_burst = 0; m_turn_w = 1;
    exp_q.delete();
  endtask

  // Grant rules in time: any grant needs 2 cycles since the last one, the same
  // queue needs 3; a weighted turn still owned by the last queue waits for it.
  task automatic model_edge();
    int c, w, cnt;
    logic allow;
    if (!rst_n) begin
      model_reset();
      return;
    end
    t++;
    allow = (t - last_any >= 2);
`ifdef VOQ_SCHED_WRR_EN
    if (m_burst > 0 && last_grant[m_ptr] == t - 2) allow = 1'b0;
`endif
    c = -1;
    if (allow)
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (c < 0 && !queue_empty[j] && m_credit[j] > 0 && sched_en && (t - last_grant[j] >= 3))
          c = j;
      end
    for (int i = 0; i < N; i++) begin
      if (credit_ret[i] && c != i) begin
        if (m_credit[i] == CMAX) m_err = 1'b1;
        else m_credit[i]++;
      end else if (!credit_ret[i] && c == i) begin
        m_credit[i]--;
      end
    end
    m_rd_en = (c >= 0);
    if (c >= 0) begin
      last_grant[c] = t;
      last_any = t;
      m_client = c;
      exp_q.push_back(2'(c));
`ifdef VOQ_SCHED_WRR_EN
      if (c == m_ptr && m_burst > 0) begin
        cnt = m_burst + 1;
        w = m_turn_w;
      end else begin
        cnt = 1;
        w = int'(cfg_weight[c*WW +: WW]);
        if (w == 0) w = 1;
        m_turn_w = w;
      end
      if (cnt >= w) begin
        m_ptr = (c + 1) % N;
        m_burst = 0;
      end else begin
        m_ptr = c;
        m_burst = cnt;
      end
`else
      w = 1; cnt = 1;
      m_ptr = (c + 1) % N;
`endif
    end
  endtask

  task automatic check_outputs();
    logic [31:0] exp_state, exp_oc;
    exp_state = (last_any == t) ? 32'(S_READ) : (last_any == t - 1) ? 32'(S_HOLD) : 32'(S_IDLE);
    chk("rd_en", rd_en, m_rd_en);
    chk("rd_client", rd_client, m_client);
    chk("out_valid", out_valid, (last_any == t - 1) ? 1 : 0);
    chk("credit_err", credit_err, m_err);
    chk("state", dbg_state, exp_state);
    if (out_valid === 1'b1) begin
      exp_oc = 32'hFF;
      if (exp_q.size() > 0) exp_oc = 32'(exp_q.pop_front());
      chk("out_client", out_client, exp_oc);
    end
    if (rd_en === 1'b1) begin
      grants[rd_client]++;
      order_q.push_back(rd_client);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic clear_counts();
    for (int i = 0; i < N; i++) grants[i] = 0;
    order_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    clear_counts();
  endtask

  function automatic logic [31:0] order_at(input int i);
    if (i < order_q.size()) return 32'(order_q[i]);
    return 32'hFF;
  endfunction

  initial begin
    model_reset();
    clear_counts();
    // reset held for 3 cycles
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;

    // all queues busy: rotate 0,1,2,3 until 4 credits per port are spent
    clear_counts();
    queue_empty = '0;
    sched_en = 1'b1;
    repeat (40) step();
    for (int i = 0; i < N; i++) chk("t2_grants", grants[i], 4);
    for (int i = 0; i < 4; i++) chk("t2_order", order_at(i), i);
    chk("t2_park", dbg_state, S_IDLE);

    // single busy queue: one grant every 3 cycles
    do_reset();
    queue_empty = 4'b1011;
    repeat (12) step();
    chk("t3_q2", grants[2], 4);
    chk("t3_q0", grants[0], 0);

    // credit starvation and recovery on queue 1
    do_reset();
    queue_empty = 4'b1101;
    repeat (16) step();
    clear_counts();
    repeat (4) step();
    chk("t4_starved", grants[1], 0);
    credit_ret = 4'b0010;
    step();
    credit_ret = '0;
    repeat (2) step();
    chk("t4_recover", grants[1], 1);

    // credit return at the maximum saturates and flags an error
    do_reset();
    queue_empty = '1;
    credit_ret = 4'b0001;
    step();
    credit_ret = '0;
    repeat (3) step();
    chk("t5_err", credit_err, 1);
    queue_empty = 4'b1110;
    repeat (16) step();
    chk("t5_sat", grants[0], 4);

`ifdef VOQ_SCHED_WRR_EN
    // weighted turn: queue 0 weight 3, others 1
    do_reset();
    cfg_weight = {3'd1, 3'd1, 3'd1, 3'd3};
    queue_empty = '0;
    repeat (30) step();
    chk("t6_order0", order_at(0), 0);
    chk("t6_order1", order_at(1), 0);
    chk("t6_order2", order_at(2), 0);
    chk("t6_order3", order_at(3), 1);
    chk("t6_order4", order_at(4), 2);
    chk("t6_order5", order_at(5), 3);
`endif

    // reset while holding a grant to queue 1
    do_reset();
    queue_empty = '0;
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      step();
      if (dbg_state === S_HOLD && rd_client === 2'd1) found = 1;
    end
    chk("wait_hold", found, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rd_en", rd_en, 0);
    chk("async_out_valid", out_valid, 0);
    step();
    rst_n = 1'b1;
    clear_counts();
    repeat (3) step();
    chk("post_reset_ptr", order_at(0), 0);

    // randomized traffic
    do_reset();
`ifdef VOQ_SCHED_WRR_EN
    cfg_weight = (N*WW)'($urandom);
`endif
    for (int k = 0; k < 400; k++) begin
      queue_empty = N'($urandom);
      sched_en = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < N; i++)
        credit_ret[i] = (m_credit[i] < CMAX) && ($urandom_range(0, 2) == 0);
      step();
    end
    credit_ret = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
